int_mul_fu: RTL and testbench

INT_MUL_FU -- requirements
Module: int_mul_fu

---
 rtl/int_mul_fu.sv | 154 +++++++++++++++
 tb/tb_int_mul_fu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/int_mul_fu.sv
// int_mul_fu: two-stage RV64 integer multiply unit (MUL/MULH/MULHSU/MULHU/MULW).
// S1 holds sign-conditioned magnitudes; the unsigned product is formed between
// S1 and S2, re-signed, and the requested slice is captured into S2.

// Unsigned N x N multiplier; either a plain '*' or a sum of MUL_SIZE-wide partial products.
module int_mul_fu_umul #(
   parameter int N        = 64,
   parameter int MUL_SIZE = 8,
   parameter int USE_DSP  = 0
) (
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic [2*N-1:0] p
);
   localparam int K = N / MUL_SIZE;

   generate
      if (USE_DSP != 0) begin : g_dsp
         assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
      end else begin : g_pp
         logic [2*N-1:0] w_pp;
         // Accumulate every shifted sub-product of the two operand chunk sets.
         always_comb begin
            p    = '0;
            w_pp = '0;
            for (int i = 0; i < K; i++) begin
               for (int j = 0; j < K; j++) begin
                  w_pp = (2*N)'(a[i*MUL_SIZE +: MUL_SIZE]) * (2*N)'(b[j*MUL_SIZE +: MUL_SIZE]);
                  p    = p + (w_pp << (MUL_SIZE * (i + j)));
               end
            end
         end
      end
   endgenerate
endmodule

module int_mul_fu #(
   parameter int N        = 64,
   parameter int TAG_W    = 6,
   parameter int MUL_SIZE = 8,
   parameter int USE_DSP  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic             in_word,
   input  logic [N-1:0]     in_a,
   input  logic [N-1:0]     in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_result,
   output logic [TAG_W-1:0] out_tag
);
   localparam logic [1:0] SEL_LO   = 2'd0;
   localparam logic [1:0] SEL_HI   = 2'd1;
   localparam logic [1:0] SEL_WORD = 2'd2;
   localparam logic [N-1:0] ONE_N  = {{(N-1){1'b0}}, 1'b1};

   function automatic logic [N-1:0] sext32(input logic [N-1:0] v);
      return {{(N-32){v[31]}}, v[31:0]};
   endfunction

   // Magnitude of a signed operand; the most-negative value maps to 2^(N-1).
   function automatic logic [N-1:0] abs_val(input logic [N-1:0] v, input logic is_signed);
      return (is_signed && v[N-1]) ? (~v + ONE_N) : v;
   endfunction

   function automatic logic [N-1:0] pick(input logic signed [2*N-1:0] prod, input logic [1:0] sel);
      logic [N-1:0] r;
      case (sel)
         SEL_LO:   r = prod[N-1:0];
         SEL_HI:   r = prod[2*N-1:N];
         default:  r = sext32(prod[N-1:0]);
      endcase
      return r;
   endfunction

   // Control state
   logic r_vld_p1, r_vld_p2;
   // Data state (not reset)
   logic [N-1:0]     r_a_p1, r_b_p1, r_res_p2;
   logic             r_neg_p1;
   logic [1:0]       r_sel_p1;
   logic [TAG_W-1:0] r_tag_p1, r_tag_p2;

   logic                  w_adv, w_acc, w_sa, w_sb, w_neg;
   logic [N-1:0]          w_a_ext, w_b_ext;
   logic [1:0]            w_sel;
   logic [2*N-1:0]        w_prod;
   logic signed [2*N-1:0] w_prod_sgn;

   assign w_adv    = r_vld_p1 && (!r_vld_p2 || out_ready);
   assign in_ready = !flush && (!r_vld_p1 || w_adv);
   assign w_acc    = in_valid && in_ready;

   // ---- p0: operand conditioning at accept ----
   assign w_a_ext = in_word ? sext32(in_a) : in_a;
   assign w_b_ext = in_word ? sext32(in_b) : in_b;
   assign w_sa    = in_word || (in_op != 2'b11);
   assign w_sb    = in_word || !in_op[1];
   assign w_neg   = (w_sa && w_a_ext[N-1]) ^ (w_sb && w_b_ext[N-1]);
   assign w_sel   = in_word ? SEL_WORD : ((in_op == 2'b00) ? SEL_LO : SEL_HI);

   // Valid bits: flush and reset dominate; S1 refills on accept, S2 on advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else if (flush) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else begin
         r_vld_p1 <= w_acc || (r_vld_p1 && !w_adv);
         r_vld_p2 <= w_adv || (r_vld_p2 && !out_ready);
      end
   end

   // ---- p1: conditioned operands ----
   // Capture conditioned operands on accept.
   always_ff @(posedge clk) begin
      if (w_acc) begin
         r_a_p1   <= abs_val(w_a_ext, w_sa);
         r_b_p1   <= abs_val(w_b_ext, w_sb);
         r_neg_p1 <= w_neg;
         r_sel_p1 <= w_sel;
         r_tag_p1 <= in_tag;
      end
   end

   int_mul_fu_umul #(.N(N), .MUL_SIZE(MUL_SIZE), .USE_DSP(USE_DSP)) u_umul (
      .a (r_a_p1),
      .b (r_b_p1),
      .p (w_prod)
   );

   assign w_prod_sgn = r_neg_p1 ? -$signed(w_prod) : $signed(w_prod);

   // ---- p2: selected result ----
   // Capture the re-signed, sliced result when S1 advances.
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_res_p2 <= pick(w_prod_sgn, r_sel_p1);
         r_tag_p2 <= r_tag_p1;
      end
   end

   assign out_valid  = r_vld_p2;
   assign out_result = r_vld_p2 ? r_res_p2 : '0;
   assign out_tag    = r_vld_p2 ? r_tag_p2 : '0;
endmodule

// File: tb/tb_int_mul_fu.sv
// Randomized and directed bench for int_mul_fu with a scoreboard model.
module tb_int_mul_fu;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, in_word, out_valid, out_ready;
   logic [1:0]  in_op;
   logic [63:0] in_a, in_b, out_result;
   logic [5:0]  in_tag, out_tag;

   int n_tests = 0;
   int n_fail  = 0;
   int n_out   = 0;

   logic [63:0] q_res[$];
   logic [5:0]  q_tag[$];

   logic        obs_vld, obs_rdy;
   logic [63:0] obs_res;
   logic [5:0]  obs_tag;

   int_mul_fu #(.N(64), .TAG_W(6), .MUL_SIZE(8), .USE_DSP(0)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
      .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: exact 128-bit signed/unsigned product from the instruction semantics.
   function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
      logic signed [127:0] xa, xb, p;
      if (w) begin
         xa = {{96{a[31]}}, a[31:0]};
         xb = {{96{b[31]}}, b[31:0]};
         p  = xa * xb;
         return {{32{p[31]}}, p[31:0]};
      end
      xa = (op != 2'b11) ? {{64{a[63]}}, a} : {64'b0, a};
      xb = (op[1] == 1'b0) ? {{64{b[63]}}, b} : {64'b0, b};
      p  = xa * xb;
      return (op == 2'b00) ? p[63:0] : p[127:64];
   endfunction

   function automatic logic [63:0] rnd64();
      case ($urandom_range(0, 6))
         0: return 64'h0;
         1: return 64'hFFFF_FFFF_FFFF_FFFF;
         2: return 64'h8000_0000_0000_0000;
         3: return 64'h7FFF_FFFF_FFFF_FFFF;
         4: return {32'($urandom), 32'h8000_0000};
         default: return {32'($urandom), 32'($urandom)};
      endcase
   endfunction

   // One clock cycle: drive at negedge, observe 1 time unit later, score, return.
   task automatic cycle(input logic v, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [5:0] tg,
                        input logic ordy, input logic fl);
      @(negedge clk);
      in_valid = v; in_op = op; in_word = w; in_a = a; in_b = b; in_tag = tg;
      out_ready = fl ? 1'b0 : ordy;
      flush = fl;
      #1;
      obs_vld = out_valid; obs_rdy = in_ready; obs_res = out_result; obs_tag = out_tag;
      if (fl) begin
         check("flush_blocks_ready", {63'b0, in_ready}, 64'd0);
         q_res.delete();
         q_tag.delete();
      end else begin
         if (out_valid) begin
            if (q_res.size() == 0) begin
               check("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
               check("result", out_result, q_res[0]);
               check("tag", {58'b0, out_tag}, {58'b0, q_tag[0]});
               if (out_ready) begin
                  void'(q_res.pop_front());
                  void'(q_tag.pop_front());
                  n_out++;
               end
            end
         end else begin
            check("idle_result_zero", out_result, 64'd0);
            check("idle_tag_zero", {58'b0, out_tag}, 64'd0);
         end
         if (v && in_ready) begin
            q_res.push_back(ref_mul(op, w, a, b));
            q_tag.push_back(tg);
         end
      end
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 2'b00, 1'b0, 64'd0, 64'd0, 6'd0, ordy, 1'b0);
   endtask

   // Single op with a free consumer: checks the exact 2-cycle latency and value.
   task automatic run_one(input string nm, input logic [1:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b, input logic [5:0] tg,
                          input logic [63:0] exp);
      cycle(1'b1, op, w, a, b, tg, 1'b1, 1'b0);
      check({nm, "_accepted"}, {63'b0, obs_rdy}, 64'd1);
      idle(1'b1);
      check({nm, "_not_early"}, {63'b0, obs_vld}, 64'd0);
      idle(1'b1);
      check({nm, "_valid"}, {63'b0, obs_vld}, 64'd1);
      check({nm, "_value"}, obs_res, exp);
      check({nm, "_tagv"}, {58'b0, obs_tag}, {58'b0, tg});
   endtask

   task automatic fill_both();
      cycle(1'b1, 2'b01, 1'b0, rnd64(), rnd64(), 6'd11, 1'b0, 1'b0);
      cycle(1'b1, 2'b10, 1'b0, rnd64(), rnd64(), 6'd12, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, n0;
      logic [1:0] op;
      logic       v, w, fl, ordy;

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_word = 1'b0;
      in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_in_ready", {63'b0, in_ready}, 64'd1);
      check("reset_out_valid", {63'b0, out_valid}, 64'd0);
      check("reset_out_result", out_result, 64'd0);
      check("reset_out_tag", {58'b0, out_tag}, 64'd0);

      // Directed corner values
      run_one("mul_m1", 2'b00, 1'b0, '1, '1, 6'd5, 64'h1);
      run_one("mulh_m1", 2'b01, 1'b0, '1, '1, 6'd5, 64'h0);
      run_one("mulhu_m1", 2'b11, 1'b0, '1, '1, 6'd5, 64'hFFFF_FFFF_FFFF_FFFE);
      run_one("mulhsu_m1", 2'b10, 1'b0, '1, '1, 6'd7, 64'hFFFF_FFFF_FFFF_FFFF);
      run_one("mulh_minneg", 2'b01, 1'b0, 64'h8000_0000_0000_0000,
              64'h8000_0000_0000_0000, 6'd9, 64'h4000_0000_0000_0000);
      run_one("mulw", 2'b00, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'h2, 6'd3,
              64'hFFFF_FFFF_FFFF_FFFE);
      run_one("mulw_opignored", 2'b11, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'h2, 6'd4,
              64'hFFFF_FFFF_FFFF_FFFE);

      // Back-to-back with a stalled consumer
      k = 0; n0 = n_out;
      for (int c = 0; c < 3; c++) begin
         cycle(1'b1, 2'($urandom), 1'b0, rnd64(), rnd64(), 6'(20 + k), 1'b0, 1'b0);
         if (obs_rdy) k++;
      end
      check("b2b_accepts_before_stall", 64'(k), 64'd2);
      check("b2b_ready_dropped", {63'b0, obs_rdy}, 64'd0);
      for (int c = 0; c < 20; c++) begin
         v = (k < 4);
         cycle(v, 2'($urandom), 1'b0, rnd64(), rnd64(), 6'(20 + k), 1'b1, 1'b0);
         if (v && obs_rdy) k++;
         if (k == 4 && q_res.size() == 0) break;
      end
      check("b2b_all_accepted", 64'(k), 64'd4);
      check("b2b_all_emerged", 64'(n_out - n0), 64'd4);

      // Flush with both stages full and a request pending
      fill_both();
      cycle(1'b1, 2'b00, 1'b0, 64'd3, 64'd4, 6'd13, 1'b1, 1'b1);
      for (int c = 0; c < 4; c++) begin
         idle(1'b1);
         check("flush_no_output", {63'b0, obs_vld}, 64'd0);
      end

      // Asynchronous reset with both stages full
      fill_both();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0;
      #1;
      check("rst_kills_out_valid", {63'b0, out_valid}, 64'd0);
      check("rst_out_result_zero", out_result, 64'd0);
      q_res.delete();
      q_tag.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_release_ready", {63'b0, in_ready}, 64'd1);
      run_one("after_rst", 2'b00, 1'b0, 64'd6, 64'hFFFF_FFFF_FFFF_FFF9, 6'd33, 64'hFFFF_FFFF_FFFF_FFD6);
      idle(1'b1);
      check("after_rst_no_stale", {63'b0, obs_vld}, 64'd0);

      // Random traffic with random backpressure and occasional flush
      for (int c = 0; c < 400; c++) begin
         v    = ($urandom_range(0, 9) < 7);
         ordy = ($urandom_range(0, 9) < 7);
         fl   = ($urandom_range(0, 49) == 0);
         w    = ($urandom_range(0, 4) == 0);
         op   = 2'($urandom);
         cycle(v, op, w, rnd64(), rnd64(), 6'($urandom), ordy, fl);
      end
      for (int c = 0; c < 10; c++) idle(1'b1);
      check("drain_empty", 64'(q_res.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
